// File: rtl/prt_frame_reader.sv
// prt_frame_reader: drains forwarded frames from the packet reference table onto
// an egress byte stream and frees every slot once its verdict has been handled.
// A downstream stall drops the PRT out of read state, so the frame is re-read
// from entry 0 and the bytes already sent are skipped.
module prt_frame_reader #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  verdict_valid,
    input  logic                  verdict_slot,
    input  logic                  verdict_forward,
    output logic                  verdict_ready,

    output logic                  EN_start_reading_prt_entry,
    output logic                  start_reading_prt_entry_slot,
    input  logic                  RDY_start_reading_prt_entry,

    output logic                  EN_read_prt_entry,
    input  logic [DATA_WIDTH:0]   read_prt_entry,
    input  logic                  RDY_read_prt_entry,

    output logic                  EN_invalidate_prt_entry,
    output logic                  invalidate_prt_entry_slot,
    input  logic                  RDY_invalidate_prt_entry,

    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,

    output logic [15:0]           frames_sent,
    output logic [15:0]           frames_dropped,
    output logic [15:0]           read_restarts
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FIFO_CW = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_STREAM  = 3'd3,
        S_STALL   = 3'd4,
        S_INVAL   = 3'd5
    } state_t;

    state_t               state;

    // Two-entry verdict FIFO, {slot, forward} per entry.
    logic [1:0]           fifo_slot;
    logic [1:0]           fifo_fwd;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [FIFO_CW-1:0]   fifo_cnt;

    // Frame progress tracking.
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic                  last_q;
    logic [CNT_W-1:0]      sent_cnt;
    logic [CNT_W-1:0]      idx;
    logic [CNT_W-1:0]      skip;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_slot;
    logic                  head_fwd;
    logic                  push;
    logic                  pop;
    logic                  rd_active;
    logic                  skipping;
    logic                  entry_flag;
    logic [DATA_WIDTH-1:0] entry_data;

    // FIFO status and PRT entry field decode.
    always_comb begin
        fifo_full  = (fifo_cnt == FIFO_CW'(2));
        fifo_empty = (fifo_cnt == FIFO_CW'(0));
        head_slot  = fifo_slot[rd_ptr];
        head_fwd   = fifo_fwd[rd_ptr];
        push       = verdict_valid && !fifo_full;
        pop        = (state == S_INVAL) && RDY_invalidate_prt_entry;
        rd_active  = ((state == S_STREAM) || (state == S_WAIT_RD)) && RDY_read_prt_entry;
        skipping   = (idx < skip);
        entry_flag = read_prt_entry[0];
        entry_data = read_prt_entry[DATA_WIDTH:1];
    end

    // PRT method enables and egress handshake, decoded from state and held byte.
    always_comb begin
        EN_start_reading_prt_entry   = 1'b0;
        EN_read_prt_entry            = 1'b0;
        EN_invalidate_prt_entry      = 1'b0;
        tx_valid                     = 1'b0;
        tx_last                      = 1'b0;
        verdict_ready                = !fifo_full;
        start_reading_prt_entry_slot = head_slot;
        invalidate_prt_entry_slot    = head_slot;
        tx_data                      = hold_data;
        case (state)
            S_START: EN_start_reading_prt_entry = RDY_start_reading_prt_entry;
            S_INVAL: EN_invalidate_prt_entry    = RDY_invalidate_prt_entry;
            S_STALL: begin
                tx_valid = 1'b1;
                tx_last  = last_q;
            end
            S_WAIT_RD, S_STREAM: begin
                if (rd_active) begin
                    if (skipping) begin
                        EN_read_prt_entry = 1'b1;
                    end else if (!hold_full) begin
                        EN_read_prt_entry = !entry_flag;
                    end else begin
                        // The entry after the held byte tells whether the held byte is last.
                        tx_valid          = 1'b1;
                        tx_last           = entry_flag;
                        EN_read_prt_entry = tx_ready && !entry_flag;
                    end
                end
            end
            default: ;
        endcase
    end

    // Verdict FIFO, frame progress, counters and state sequencing.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= S_IDLE;
            fifo_slot      <= '0;
            fifo_fwd       <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= '0;
            hold_data      <= '0;
            hold_full      <= 1'b0;
            last_q         <= 1'b0;
            sent_cnt       <= '0;
            idx            <= '0;
            skip           <= '0;
            frames_sent    <= '0;
            frames_dropped <= '0;
            read_restarts  <= '0;
        end else begin
            if (push) begin
                fifo_slot[wr_ptr] <= verdict_slot;
                fifo_fwd[wr_ptr]  <= verdict_forward;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            fifo_cnt <= fifo_cnt + FIFO_CW'(push) - FIFO_CW'(pop);

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_fwd) begin
                            skip     <= '0;
                            sent_cnt <= '0;
                            state    <= S_START;
                        end else begin
                            state <= S_INVAL;
                        end
                    end
                end
                S_START: begin
                    if (RDY_start_reading_prt_entry) begin
                        idx   <= '0;
                        state <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD, S_STREAM: begin
                    if (rd_active) begin
                        state <= S_STREAM;
                        if (skipping) begin
                            idx <= idx + CNT_W'(1);
                        end else if (!hold_full) begin
                            if (entry_flag) begin
                                state <= S_INVAL;
                            end else begin
                                hold_data <= entry_data;
                                hold_full <= 1'b1;
                                sent_cnt  <= sent_cnt + CNT_W'(1);
                                idx       <= idx + CNT_W'(1);
                            end
                        end else if (tx_ready) begin
                            if (entry_flag) begin
                                hold_full <= 1'b0;
                                state     <= S_INVAL;
                            end else begin
                                hold_data <= entry_data;
                                sent_cnt  <= sent_cnt + CNT_W'(1);
                                idx       <= idx + CNT_W'(1);
                            end
                        end else begin
                            // PRT drops out of read state now; remember the end flag for the stall.
                            last_q <= entry_flag;
                            state  <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (tx_ready) begin
                        hold_full <= 1'b0;
                        if (last_q) begin
                            state <= S_INVAL;
                        end else begin
                            skip          <= sent_cnt;
                            read_restarts <= read_restarts + CNT_W'(1);
                            state         <= S_START;
                        end
                    end
                end
                S_INVAL: begin
                    if (RDY_invalidate_prt_entry) begin
                        if (head_fwd) begin
                            frames_sent <= frames_sent + CNT_W'(1);
                        end else begin
                            frames_dropped <= frames_dropped + CNT_W'(1);
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prt_frame_reader.sv
// Self-checking bench for prt_frame_reader with a behavioural PRT model and
// scoreboards for egress beats and invalidated slots.
module tb_prt_frame_reader;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          verdict_valid = 1'b0;
    logic          verdict_slot = 1'b0;
    logic          verdict_forward = 1'b0;
    logic          verdict_ready;
    logic          EN_start_reading_prt_entry;
    logic          start_reading_prt_entry_slot;
    logic          RDY_start_reading_prt_entry = 1'b1;
    logic          EN_read_prt_entry;
    logic [DW:0]   read_prt_entry;
    logic          RDY_read_prt_entry;
    logic          EN_invalidate_prt_entry;
    logic          invalidate_prt_entry_slot;
    logic          RDY_invalidate_prt_entry = 1'b1;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready = 1'b1;
    logic [15:0]   frames_sent;
    logic [15:0]   frames_dropped;
    logic [15:0]   read_restarts;

    prt_frame_reader #(.DATA_WIDTH(DW)) dut (
        .CLK                          (CLK),
        .RST_N                        (RST_N),
        .verdict_valid                (verdict_valid),
        .verdict_slot                 (verdict_slot),
        .verdict_forward              (verdict_forward),
        .verdict_ready                (verdict_ready),
        .EN_start_reading_prt_entry   (EN_start_reading_prt_entry),
        .start_reading_prt_entry_slot (start_reading_prt_entry_slot),
        .RDY_start_reading_prt_entry  (RDY_start_reading_prt_entry),
        .EN_read_prt_entry            (EN_read_prt_entry),
        .read_prt_entry               (read_prt_entry),
        .RDY_read_prt_entry           (RDY_read_prt_entry),
        .EN_invalidate_prt_entry      (EN_invalidate_prt_entry),
        .invalidate_prt_entry_slot    (invalidate_prt_entry_slot),
        .RDY_invalidate_prt_entry     (RDY_invalidate_prt_entry),
        .tx_data                      (tx_data),
        .tx_valid                     (tx_valid),
        .tx_last                      (tx_last),
        .tx_ready                     (tx_ready),
        .frames_sent                  (frames_sent),
        .frames_dropped               (frames_dropped),
        .read_restarts                (read_restarts)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // PRT model: read state two cycles after an accepted start-read, lost on an idle read cycle.
    logic [7:0] fmem [2][16];
    int         flen [2];
    logic       m_pend = 1'b0;
    logic       m_in_read = 1'b0;
    logic       m_slot = 1'b0;
    int         m_ptr = 0;

    always @(posedge CLK) begin
        if (m_pend) begin
            m_pend    <= 1'b0;
            m_in_read <= 1'b1;
            m_ptr     <= 0;
        end else if (m_in_read) begin
            if (EN_read_prt_entry) m_ptr <= m_ptr + 1;
            else                   m_in_read <= 1'b0;
        end
        if (EN_start_reading_prt_entry && RDY_start_reading_prt_entry) begin
            m_pend    <= 1'b1;
            m_in_read <= 1'b0;
            m_slot    <= start_reading_prt_entry_slot;
        end
    end

    always_comb begin
        RDY_read_prt_entry = m_in_read;
        if (m_ptr < flen[m_slot]) read_prt_entry = {fmem[m_slot][m_ptr[3:0]], 1'b0};
        else                      read_prt_entry = {8'h00, 1'b1};
    end

    // Scoreboards and bookkeeping.
    logic [8:0] exp_beats [$];
    logic       exp_inval [$];
    int         beat_cyc [$];
    int         inval_cyc = -1;
    int         errors = 0;
    int         checks = 0;
    int         exp_sent = 0;
    int         exp_drop = 0;
    int         exp_restart = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       stall_last = 1'b0;
    logic       acc = 1'b0;

    // One clock: sample outputs at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [8:0] e;
        logic       es;
        @(negedge CLK);
        checks++;
        if ((int'(EN_start_reading_prt_entry) + int'(EN_read_prt_entry) + int'(EN_invalidate_prt_entry)) > 1) begin
            errors++;
            $display("FAIL en_exclusive cyc=%0d: start=%0b read=%0b inval=%0b, required at most one high",
                     cyc, EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry);
        end
        if (stall_prev) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== stall_data || tx_last !== stall_last) begin
                errors++;
                $display("FAIL stall_stable cyc=%0d: valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                         cyc, tx_valid, tx_data, tx_last, stall_data, stall_last);
            end
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
        stall_last = tx_last;
        if (tx_valid && tx_ready) begin
            checks++;
            beat_cyc.push_back(cyc);
            if (exp_beats.size() == 0) begin
                errors++;
                $display("FAIL tx_beat cyc=%0d: unexpected beat data=%0d last=%0b", cyc, tx_data, tx_last);
            end else begin
                e = exp_beats.pop_front();
                if ({tx_last, tx_data} !== e) begin
                    errors++;
                    $display("FAIL tx_beat cyc=%0d: got data=%0d last=%0b, required data=%0d last=%0b",
                             cyc, tx_data, tx_last, e[7:0], e[8]);
                end
            end
        end
        if (EN_invalidate_prt_entry && RDY_invalidate_prt_entry) begin
            checks++;
            inval_cyc = cyc;
            if (exp_inval.size() == 0) begin
                errors++;
                $display("FAIL inval_slot cyc=%0d: unexpected invalidate slot=%0b", cyc, invalidate_prt_entry_slot);
            end else begin
                es = exp_inval.pop_front();
                if (invalidate_prt_entry_slot !== es) begin
                    errors++;
                    $display("FAIL inval_slot cyc=%0d: got slot=%0b, required %0b", cyc, invalidate_prt_entry_slot, es);
                end
            end
        end
        acc = 1'b0;
        if (verdict_valid && verdict_ready) begin
            acc = 1'b1;
            exp_inval.push_back(verdict_slot);
            if (verdict_forward) begin
                for (int i = 0; i < flen[verdict_slot]; i++)
                    exp_beats.push_back({(i == flen[verdict_slot] - 1), fmem[verdict_slot][i]});
                exp_sent++;
            end else begin
                exp_drop++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_verdict(input logic slot, input logic fwd, output int acc_cyc, output int waits);
        int c;
        verdict_valid   = 1'b1;
        verdict_slot    = slot;
        verdict_forward = fwd;
        waits   = 0;
        acc_cyc = -1;
        for (int n = 0; n < 60; n++) begin
            c = cyc;
            tick();
            if (acc) begin
                acc_cyc = c;
                break;
            end
            waits++;
        end
        verdict_valid = 1'b0;
        if (acc_cyc < 0) begin
            errors++;
            $display("FAIL push_timeout: verdict slot=%0b not accepted within 60 cycles", slot);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_beats.size() != 0 || exp_inval.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_beats.size() != 0 || exp_inval.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: beats left=%0d invals left=%0d, required 0 0",
                     exp_beats.size(), exp_inval.size());
        end
        tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry, start_reading_prt_entry_slot,
             invalidate_prt_entry_slot, tx_valid, tx_last, verdict_ready, tx_data, frames_sent, frames_dropped,
             read_restarts} !== {8'b0000_0001, 8'h00, 48'h0}) begin
            errors++;
            $display("FAIL reset_state: en=%b%b%b vready=%0b tx_valid=%0b tx_last=%0b tx_data=%0d cnt=%0d/%0d/%0d, required all 0 and vready=1",
                     EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry, verdict_ready,
                     tx_valid, tx_last, tx_data, frames_sent, frames_dropped, read_restarts);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_counters(input string name);
        checks++;
        if (frames_sent !== 16'(exp_sent) || frames_dropped !== 16'(exp_drop) || read_restarts !== 16'(exp_restart)) begin
            errors++;
            $display("FAIL counters_%s: sent=%0d dropped=%0d restarts=%0d, required %0d %0d %0d",
                     name, frames_sent, frames_dropped, read_restarts, exp_sent, exp_drop, exp_restart);
        end
    endtask

    task automatic test_forward();
        int p, w;
        fmem[0][0] = 8'd11; fmem[0][1] = 8'd22; fmem[0][2] = 8'd33; flen[0] = 3;
        beat_cyc.delete();
        push_verdict(1'b0, 1'b1, p, w);
        wait_done();
        checks++;
        if (beat_cyc.size() != 3 || beat_cyc[0] != p + 5 || beat_cyc[2] != p + 7) begin
            errors++;
            $display("FAIL fwd_timing: beats=%0d first=%0d last=%0d, required 3 beats at %0d..%0d",
                     beat_cyc.size(), (beat_cyc.size() > 0) ? beat_cyc[0] - p : -1,
                     (beat_cyc.size() > 2) ? beat_cyc[2] - p : -1, 5, 7);
        end
        checks++;
        if (inval_cyc != p + 8) begin
            errors++;
            $display("FAIL fwd_inval_cycle: got +%0d, required +8", inval_cyc - p);
        end
        test_counters("forward");
    endtask

    task automatic test_drop();
        int p, w;
        beat_cyc.delete();
        push_verdict(1'b1, 1'b0, p, w);
        wait_done();
        checks++;
        if (inval_cyc != p + 2) begin
            errors++;
            $display("FAIL drop_inval_cycle: got +%0d, required +2", inval_cyc - p);
        end
        checks++;
        if (beat_cyc.size() != 0) begin
            errors++;
            $display("FAIL drop_no_beat: got %0d beats, required 0", beat_cyc.size());
        end
        test_counters("drop");
    endtask

    task automatic test_stall();
        int p, w;
        for (int i = 0; i < 5; i++) fmem[0][i] = 8'(i + 1);
        flen[0] = 5;
        beat_cyc.delete();
        push_verdict(1'b0, 1'b1, p, w);
        while (cyc < p + 6) tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'd2 || tx_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_present: valid=%0b data=%0d last=%0b, required 1 2 0", tx_valid, tx_data, tx_last);
        end
        tx_ready = 1'b0;
        repeat (4) tick();
        tx_ready = 1'b1;
        exp_restart++;
        wait_done();
        checks++;
        if (beat_cyc.size() != 5) begin
            errors++;
            $display("FAIL stall_beats: got %0d beats, required 5", beat_cyc.size());
        end
        test_counters("stall");
    endtask

    task automatic test_zero_len();
        int p, w;
        flen[1] = 0;
        beat_cyc.delete();
        push_verdict(1'b1, 1'b1, p, w);
        wait_done();
        checks++;
        if (beat_cyc.size() != 0) begin
            errors++;
            $display("FAIL zero_len_beats: got %0d beats, required 0", beat_cyc.size());
        end
        test_counters("zero_len");
    endtask

    task automatic test_back_to_back();
        int p0, p1, p2, w0, w1, w2;
        for (int i = 0; i < 6; i++) fmem[0][i] = 8'(8'h40 + i);
        flen[0] = 6;
        fmem[1][0] = 8'hA1; fmem[1][1] = 8'hA2; flen[1] = 2;
        push_verdict(1'b0, 1'b1, p0, w0);
        push_verdict(1'b1, 1'b0, p1, w1);
        push_verdict(1'b1, 1'b1, p2, w2);
        checks++;
        if (w0 != 0 || w1 != 0 || w2 == 0) begin
            errors++;
            $display("FAIL b2b_ready: waits=%0d/%0d/%0d, required 0/0/>0", w0, w1, w2);
        end
        wait_done();
        test_counters("back_to_back");
    endtask

    task automatic test_reset_mid();
        int p, w, n;
        for (int i = 0; i < 8; i++) fmem[0][i] = 8'(8'h10 + i);
        flen[0] = 8;
        beat_cyc.delete();
        push_verdict(1'b0, 1'b1, p, w);
        n = 0;
        while (beat_cyc.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry, start_reading_prt_entry_slot,
             invalidate_prt_entry_slot, tx_valid, tx_last, verdict_ready, tx_data, frames_sent, frames_dropped,
             read_restarts} !== {8'b0000_0001, 8'h00, 48'h0}) begin
            errors++;
            $display("FAIL reset_mid: en=%b%b%b vready=%0b tx_valid=%0b tx_last=%0b tx_data=%0d cnt=%0d/%0d/%0d, required all 0 and vready=1",
                     EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry, verdict_ready,
                     tx_valid, tx_last, tx_data, frames_sent, frames_dropped, read_restarts);
        end
        exp_beats.delete();
        exp_inval.delete();
        exp_sent = 0;
        exp_drop = 0;
        exp_restart = 0;
        stall_prev = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        fmem[1][0] = 8'h5A; fmem[1][1] = 8'h5B; flen[1] = 2;
        push_verdict(1'b1, 1'b1, p, w);
        wait_done();
        test_counters("after_reset");
    endtask

    initial begin
        flen[0] = 0;
        flen[1] = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) fmem[s][i] = 8'h00;
        test_reset();
        test_forward();
        test_drop();
        test_stall();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
